mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 15 +
 rtl/mem_port_arbiter_lat_cnt.sv | 27 ++
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encoding and
// parameter defaults.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_D  = 2'd2
  } arb_state_t;

  localparam int MEM_LAT_DEF    = 2;
  localparam int STARVE_MAX_DEF = 2;
  localparam int LAT_W          = 3;

endpackage

// File: rtl/mem_port_arbiter_lat_cnt.sv
// Loadable 3-bit down-counter that counts down to zero and then holds there.
// The done output is high whenever the count is zero.
module arb_lat_cnt
  import mem_port_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  output logic             done
);

  logic [LAT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - LAT_W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter shared by instruction fetch and the MEM stage.
// state      | meaning
// ST_IDLE    | accepting requests; ack of the previous access may be visible
// ST_BUSY_IF | fetch access in flight, waiting for the latency count to run out
// ST_BUSY_D  | data access in flight, waiting for the latency count to run out
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LAT    = MEM_LAT_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_mem
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STREAK_TOP = SW'(STARVE_MAX);

  arb_state_t    state, state_nxt;
  logic [SW-1:0] streak;
  logic          acc_we;
  logic          elig_if, elig_d, pick_d, pick_if, grant;
  logic          cnt_done, finish;

  // A requester whose ack is showing this cycle has already been served.
  assign elig_if = if_req & ~if_ack;
  assign elig_d  = d_req & ~d_ack;
  assign pick_d  = elig_d & (~elig_if | (streak != STREAK_TOP));
  assign pick_if = elig_if & ~pick_d;
  assign grant   = (state == ST_IDLE) & (pick_d | pick_if);
  assign finish  = (state != ST_IDLE) & cnt_done;

  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = d_req & ~d_ack;

  arb_lat_cnt u_lat_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (grant),
    .load_val (LAT_W'(MEM_LAT)),
    .done     (cnt_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (pick_d) begin
          state_nxt = ST_BUSY_D;
        end else if (pick_if) begin
          state_nxt = ST_BUSY_IF;
        end
      end
      ST_BUSY_IF, ST_BUSY_D: begin
        if (cnt_done) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      acc_we    <= 1'b0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      streak    <= '0;
    end else begin
      mem_en <= grant;
      mem_we <= grant & pick_d & d_we;
      if_ack <= finish & (state == ST_BUSY_IF);
      d_ack  <= finish & (state == ST_BUSY_D);
      if (grant) begin
        mem_addr <= pick_d ? d_addr : if_addr;
        acc_we   <= pick_d & d_we;
        if (pick_d) begin
          mem_wdata <= d_wdata;
        end
      end
      if (finish && (state == ST_BUSY_IF)) begin
        if_rdata <= mem_rdata;
      end
      if (finish && (state == ST_BUSY_D) && !acc_we) begin
        d_rdata <= mem_rdata;
      end
      // Streak only counts data wins taken while fetch was waiting.
      if (grant && pick_if) begin
        streak <= '0;
      end else if (grant && pick_d && if_req && (streak != STREAK_TOP)) begin
        streak <= streak + SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand sequences for
// ordering/reset corner cases, then random traffic against a timestamp model.
module tb_mem_port_arbiter;

  localparam int LAT    = 2;
  localparam int STARVE = 2;

  logic        clk = 1'b0;
  logic        reset, if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic        if_ack, d_ack, mem_en, mem_we, stall_if, stall_mem;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ireq, ia, dreq, dwe, da, dw, mrd;
    logic [31:0] en, we, iack, dack, sif, smem, addr, wdata, ird, drd;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit rnd_mem = 1'b0;
  logic [31:0] glog[$];

  logic [31:0] s_en, s_we, s_iack, s_dack, s_sif, s_smem, s_addr, s_wdata, s_ird, s_drd;

  bit          m_busy, m_owner_d, m_we, m_ack_if, m_ack_d;
  int          m_grant, m_streak;
  logic [31:0] m_addr, m_wdata, m_if_rd, m_d_rd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic m_clear();
    m_busy = 0; m_owner_d = 0; m_we = 0; m_ack_if = 0; m_ack_d = 0;
    m_grant = -10; m_streak = 0;
    m_addr = '0; m_wdata = '0; m_if_rd = '0; m_d_rd = '0;
  endtask

  // Access granted in cycle g strobes in g+1, data returns in g+1+LAT, ack in g+2+LAT.
  task automatic model_step();
    bit e_if, e_d, na_if, na_d, strobe;
    if (reset) m_clear();
    strobe = m_busy && (cyc == m_grant + 1);
    chk("mem_en", s_en, 32'(strobe));
    chk("mem_we", s_we, 32'(strobe && m_owner_d && m_we));
    chk("mem_addr", s_addr, m_addr);
    chk("mem_wdata", s_wdata, m_wdata);
    chk("if_ack", s_iack, 32'(m_ack_if));
    chk("d_ack", s_dack, 32'(m_ack_d));
    chk("if_rdata", s_ird, m_if_rd);
    chk("d_rdata", s_drd, m_d_rd);
    chk("stall_if", s_sif, 32'(if_req && !m_ack_if));
    chk("stall_mem", s_smem, 32'(d_req && !m_ack_d));
    if (!reset) begin
      na_if = 0; na_d = 0;
      if (m_busy) begin
        if (cyc == m_grant + 1 + LAT) begin
          if (m_owner_d) begin
            if (!m_we) m_d_rd = mem_rdata;
            na_d = 1;
          end else begin
            m_if_rd = mem_rdata;
            na_if = 1;
          end
          m_busy = 0;
        end
      end else begin
        e_if = if_req && !m_ack_if;
        e_d  = d_req && !m_ack_d;
        if (e_d && (!e_if || m_streak < STARVE)) begin
          m_owner_d = 1; m_we = d_we; m_addr = d_addr; m_wdata = d_wdata;
          m_busy = 1; m_grant = cyc;
          if (if_req && m_streak < STARVE) m_streak++;
        end else if (e_if) begin
          m_owner_d = 0; m_we = 0; m_addr = if_addr;
          m_busy = 1; m_grant = cyc; m_streak = 0;
        end
      end
      m_ack_if = na_if;
      m_ack_d  = na_d;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    s_en = 32'(mem_en); s_we = 32'(mem_we); s_iack = 32'(if_ack); s_dack = 32'(d_ack);
    s_sif = 32'(stall_if); s_smem = 32'(stall_mem);
    s_addr = mem_addr; s_wdata = mem_wdata; s_ird = if_rdata; s_drd = d_rdata;
    if (mem_en) glog.push_back(mem_addr);
    model_step();
    cyc++;
    @(posedge clk);
    #1;
    if (rnd_mem) mem_rdata = $urandom();
  endtask

  task automatic run_until(input bit want_d, input int max_cyc, output bit seen);
    seen = 0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      tick();
      if (want_d ? s_dack[0] : s_iack[0]) seen = 1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  function automatic vec_t mk(
    input logic [31:0] ireq, ia, dreq, dwe, da, dw, mrd,
    input logic [31:0] en, we, iack, dack, sif, smem, addr, wdata, ird, drd);
    vec_t v;
    v.ireq = ireq; v.ia = ia; v.dreq = dreq; v.dwe = dwe; v.da = da; v.dw = dw; v.mrd = mrd;
    v.en = en; v.we = we; v.iack = iack; v.dack = dack; v.sif = sif; v.smem = smem;
    v.addr = addr; v.wdata = wdata; v.ird = ird; v.drd = drd;
    return v;
  endfunction

  vec_t        vecs[22];
  logic [31:0] exp_a[4];
  logic [31:0] exp_b[4];
  bit          seen, if_done;
  int          n_st, nack;

  initial begin
    // fetch of 0x40, store to 0x200, then simultaneous load 0x100 + fetch 0x80
    vecs[0]  = mk(1,'h40,0,0,0,0,0,                   0,0,0,0,1,0, 0,0,0,0);
    vecs[1]  = mk(1,'h40,0,0,0,0,0,                   1,0,0,0,1,0, 'h40,0,0,0);
    vecs[2]  = mk(1,'h40,0,0,0,0,0,                   0,0,0,0,1,0, 'h40,0,0,0);
    vecs[3]  = mk(1,'h40,0,0,0,0,'h20080005,          0,0,0,0,1,0, 'h40,0,0,0);
    vecs[4]  = mk(1,'h40,0,0,0,0,0,                   0,0,1,0,0,0, 'h40,0,'h20080005,0);
    vecs[5]  = mk(0,0,0,0,0,0,0,                      0,0,0,0,0,0, 'h40,0,'h20080005,0);
    vecs[6]  = mk(0,0,1,1,'h200,'hdeadbeef,0,         0,0,0,0,0,1, 'h40,0,'h20080005,0);
    vecs[7]  = mk(0,0,1,1,'h200,'hdeadbeef,0,         1,1,0,0,0,1, 'h200,'hdeadbeef,'h20080005,0);
    vecs[8]  = mk(0,0,1,1,'h200,'hdeadbeef,0,         0,0,0,0,0,1, 'h200,'hdeadbeef,'h20080005,0);
    vecs[9]  = mk(0,0,1,1,'h200,'hdeadbeef,'h12345678,0,0,0,0,0,1, 'h200,'hdeadbeef,'h20080005,0);
    vecs[10] = mk(0,0,1,1,'h200,'hdeadbeef,0,         0,0,0,1,0,0, 'h200,'hdeadbeef,'h20080005,0);
    vecs[11] = mk(0,0,0,0,0,0,0,                      0,0,0,0,0,0, 'h200,'hdeadbeef,'h20080005,0);
    vecs[12] = mk(1,'h80,1,0,'h100,0,0,               0,0,0,0,1,1, 'h200,'hdeadbeef,'h20080005,0);
    vecs[13] = mk(1,'h80,1,0,'h100,0,0,               1,0,0,0,1,1, 'h100,0,'h20080005,0);
    vecs[14] = mk(1,'h80,1,0,'h100,0,0,               0,0,0,0,1,1, 'h100,0,'h20080005,0);
    vecs[15] = mk(1,'h80,1,0,'h100,0,'hcafe0001,      0,0,0,0,1,1, 'h100,0,'h20080005,0);
    vecs[16] = mk(1,'h80,1,0,'h100,0,0,               0,0,0,1,1,0, 'h100,0,'h20080005,'hcafe0001);
    vecs[17] = mk(1,'h80,0,0,0,0,0,                   1,0,0,0,1,0, 'h80,0,'h20080005,'hcafe0001);
    vecs[18] = mk(1,'h80,0,0,0,0,0,                   0,0,0,0,1,0, 'h80,0,'h20080005,'hcafe0001);
    vecs[19] = mk(1,'h80,0,0,0,0,'h0badf00d,          0,0,0,0,1,0, 'h80,0,'h20080005,'hcafe0001);
    vecs[20] = mk(1,'h80,0,0,0,0,0,                   0,0,1,0,0,0, 'h80,0,'h0badf00d,'hcafe0001);
    vecs[21] = mk(0,0,0,0,0,0,0,                      0,0,0,0,0,0, 'h80,0,'h0badf00d,'hcafe0001);
    exp_a = '{32'h300, 32'h304, 32'h500, 32'h308};
    exp_b = '{32'h700, 32'h704, 32'h600, 32'h708};

    m_clear();
    reset = 1'b1; if_req = 0; d_req = 0; d_we = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    @(posedge clk); #1;
    tick();
    if_req = 1'b1; if_addr = 'h40;
    tick();
    chk("rst_mem_en", s_en, 0);
    chk("rst_mem_addr", s_addr, 0);
    chk("rst_if_ack", s_iack, 0);
    chk("rst_if_rdata", s_ird, 0);
    chk("rst_stall_if", s_sif, 1);

    reset = 1'b0;
    for (int r = 0; r < 22; r++) begin
      if_req = vecs[r].ireq[0]; if_addr = vecs[r].ia;
      d_req = vecs[r].dreq[0]; d_we = vecs[r].dwe[0];
      d_addr = vecs[r].da; d_wdata = vecs[r].dw; mem_rdata = vecs[r].mrd;
      tick();
      chk($sformatf("v%0d_mem_en", r), s_en, vecs[r].en);
      chk($sformatf("v%0d_mem_we", r), s_we, vecs[r].we);
      chk($sformatf("v%0d_if_ack", r), s_iack, vecs[r].iack);
      chk($sformatf("v%0d_d_ack", r), s_dack, vecs[r].dack);
      chk($sformatf("v%0d_stall_if", r), s_sif, vecs[r].sif);
      chk($sformatf("v%0d_stall_mem", r), s_smem, vecs[r].smem);
      chk($sformatf("v%0d_mem_addr", r), s_addr, vecs[r].addr);
      chk($sformatf("v%0d_mem_wdata", r), s_wdata, vecs[r].wdata);
      chk($sformatf("v%0d_if_rdata", r), s_ird, vecs[r].ird);
      chk($sformatf("v%0d_d_rdata", r), s_drd, vecs[r].drd);
    end

    // continuous stores with fetch arriving mid-stream: D,D,IF,D
    rnd_mem = 1'b1;
    do_reset();
    glog.delete();
    d_req = 1; d_we = 1; d_addr = 'h300; d_wdata = 'h1;
    n_st = 0; if_done = 0;
    for (int i = 0; i < 120 && !(n_st == 3 && if_done); i++) begin
      tick();
      if (s_dack[0]) begin
        n_st++;
        if (n_st < 3) begin
          d_addr = 32'('h300 + 4 * n_st); d_wdata = 32'(n_st + 1);
        end else begin
          d_req = 0;
        end
      end
      if (s_iack[0]) begin
        if_req = 0; if_done = 1;
      end else if (!if_done && !if_req && glog.size() == 2) begin
        if_req = 1; if_addr = 'h500;
      end
    end
    chk("seqA_grants", glog.size(), 4);
    if (glog.size() == 4) for (int k = 0; k < 4; k++) chk($sformatf("seqA_order%0d", k), glog[k], exp_a[k]);

    // starvation: two contested data wins, then fetch is forced ahead
    do_reset();
    glog.delete();
    if_req = 1; if_addr = 'h600; d_req = 1; d_we = 0; d_addr = 'h700;
    tick(); if_req = 0;
    run_until(1, 20, seen); chk("seqB_ack1", 32'(seen), 1); d_req = 0; tick();
    if_req = 1; d_req = 1; d_addr = 'h704;
    tick(); if_req = 0;
    run_until(1, 20, seen); chk("seqB_ack2", 32'(seen), 1); d_req = 0; tick();
    if_req = 1; d_req = 1; d_addr = 'h708;
    run_until(0, 20, seen); chk("seqB_if_ack", 32'(seen), 1); if_req = 0;
    run_until(1, 20, seen); chk("seqB_ack3", 32'(seen), 1); d_req = 0; tick();
    chk("seqB_grants", glog.size(), 4);
    if (glog.size() == 4) for (int k = 0; k < 4; k++) chk($sformatf("seqB_order%0d", k), glog[k], exp_b[k]);

    // reset one cycle before the data ack abandons the access
    do_reset();
    glog.delete();
    d_req = 1; d_we = 0; d_addr = 'h800;
    tick(); tick();
    chk("seqC_strobe", glog.size(), 1);
    tick();
    reset = 1; d_req = 0;
    tick();
    chk("seqC_rst_mem_addr", s_addr, 0);
    chk("seqC_rst_d_rdata", s_drd, 0);
    chk("seqC_rst_d_ack", s_dack, 0);
    reset = 0;
    nack = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (s_dack[0]) nack++;
    end
    chk("seqC_no_ack", nack, 0);
    d_req = 1; d_addr = 'h804;
    run_until(1, 20, seen); chk("seqC_served", 32'(seen), 1); d_req = 0; tick();
    chk("seqC_grants", glog.size(), 2);

    // fetch request still high during its ack cycle: single access only
    glog.delete();
    if_req = 1; if_addr = 'h900;
    run_until(0, 20, seen); chk("seqD_ack", 32'(seen), 1);
    if_req = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("seqD_one_access", glog.size(), 1);

    // random traffic with occasional drops and resets
    for (int i = 0; i < 3000; i++) begin
      if (reset) reset = 0;
      else if ($urandom_range(0, 399) == 0) reset = 1;
      if (!if_req) begin
        if ($urandom_range(0, 3) == 0) begin if_req = 1; if_addr = $urandom(); end
      end else if (s_iack[0]) begin
        if ($urandom_range(0, 3) != 0) if_req = 0;
        else if_addr = $urandom();
      end else if ($urandom_range(0, 59) == 0) begin
        if_req = 0;
      end
      if (!d_req) begin
        if ($urandom_range(0, 2) == 0) begin
          d_req = 1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom(); d_wdata = $urandom();
        end
      end else if (s_dack[0]) begin
        if ($urandom_range(0, 3) != 0) d_req = 0;
        else begin d_we = 1'($urandom_range(0, 1)); d_addr = $urandom(); d_wdata = $urandom(); end
      end else if ($urandom_range(0, 59) == 0) begin
        d_req = 0;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
